debounce_multi: RTL and testbench
=================================

// Module: debounce_multi
// PURPOSE
//  Multi-channel button debouncer with edge-event outputs. Debounces each raw
//  input independently and emits one-cycle press and release pulses per channel.
//  Sits between board push-buttons/switches and the control FSMs, replacing the
//  per-button single-channel debouncers. Includes an input synchroniser.
// PARAMETERS
//  CHANNELS        4    number of independent input channels (>=1)
//  DEBOUNCE_DELAY  10   consecutive stable cycles required to accept a change (>=1)
//  COUNTER_BITS    20   per-channel counter width; DEBOUNCE_DELAY < 2**COUNTER_BITS
//  ACTIVE_LOW      0    1: raw inputs inverted after sync (pressed = electrical 0)
//  LONG_DELAY      1000 cycles held before long_press fires (DEBOUNCE_LONGPRESS_EN only)
// PORTS
//  clk         in   1         system clock, all logic on posedge
//  reset       in   1         synchronous, active-high reset
//  button_in   in   CHANNELS  raw, asynchronous, noisy inputs
//  button_out  out  CHANNELS  debounced level, 1 = pressed
//  press       out  CHANNELS  1-cycle pulse on accepted 0->1 of button_out
//  release     out  CHANNELS  1-cycle pulse on accepted 1->0 of button_out
//  long_press  out  CHANNELS  1-cycle pulse after LONG_DELAY held cycles
// BEHAVIOUR
//  - One clock, clk; reset synchronous, active-high; all state on posedge clk.
//  - Reset: sync flops, counters, button_out, press, release, long_press all 0.
//    Reset mid-count discards progress; no pulses are generated by reset.
//  - Synchroniser: 2-flop per channel; s = sync2 ^ ACTIVE_LOW.
//  - Per channel, every cycle out of reset:
//    s == button_out             -> cnt <= 0 (any mismatch run is cancelled)
//    s != button_out, cnt < D-1  -> cnt <= cnt + 1
//    s != button_out, cnt == D-1 -> button_out <= s, cnt <= 0, pulse
//    where D = DEBOUNCE_DELAY. A mismatch run shorter than D cycles is a glitch
//    and never reaches button_out.
//  - Latency: a clean step on button_in at clk edge k gives button_out change at
//    edge k+2+D (2 sync stages + D cycles).
//  - press/release: registered, asserted for exactly the cycle in which the new
//    button_out value is first visible; never both high on one channel.
//  - Channels are fully independent; simultaneous changes on several channels
//    produce simultaneous pulses. There is no priority and no coupling.
//  - Counter never wraps; it saturates in effect because it is cleared at D-1.
// CONFIGURATION
//  DEBOUNCE_LONGPRESS_EN defined:
//    - Per-channel hold counter of width $clog2(LONG_DELAY+1).
//    - The counter clears while button_out == 0.
//    - While button_out == 1 it counts up to LONG_DELAY and then holds.
//    - long_press pulses for 1 cycle when the counter reaches LONG_DELAY, i.e.
//      LONG_DELAY cycles after press. It fires once per press; releasing re-arms it.
//  DEBOUNCE_LONGPRESS_EN undefined:
//    - No hold counters are built.
//    - long_press is tied to 0; the port list is unchanged.
// TESTING (CHANNELS=4, DEBOUNCE_DELAY=8, LONG_DELAY=20)
//  1. Reset held 5 cycles, inputs 4'hF -> all outputs 0 during reset and on the
//     first cycle after it.
//  2. Bounce: ch0 toggles every 3 cycles for 30 cycles, then holds 1 ->
//     - button_out[0] rises exactly 10 cycles after the last edge;
//     - press[0] is high for 1 cycle;
//     - no output activity during the bounce.
//  3. Glitch: ch2 high for 7 cycles, then low -> button_out[2], press[2] and
//     release[2] stay 0. Repeat with 8 cycles -> press[2] then release[2],
//     8 cycles apart.
//  4. ch1 and ch3 step to 1 on the same edge -> press[1] and press[3] both
//     pulse on the same cycle, and ch0/ch2 stay unaffected.
//  5. ch0 step to 1; assert reset 5 cycles later for 1 cycle ->
//     - all outputs return to 0 with no pulses;
//     - button_out[0] rises 2+8 cycles after reset deasserts.
//  6. With the macro: ch0 held 40 cycles after press[0] -> a single long_press[0]
//     pulse 20 cycles after press[0]; a second press re-fires it. Without the
//     macro: long_press stays 4'h0 throughout.

Source files
------------

// File: rtl/debounce_multi.sv
// Multi-channel push-button debouncer: 2-flop synchroniser, per-channel stability counter,
// one-cycle press/release pulses and an optional long-press pulse (`DEBOUNCE_LONGPRESS_EN).
// The release pulse port is named release_pulse because "release" is a SystemVerilog keyword.
module debounce_multi #(
    parameter int unsigned CHANNELS       = 4,
    parameter int unsigned DEBOUNCE_DELAY = 10,
    parameter int unsigned COUNTER_BITS   = 20,
    parameter bit          ACTIVE_LOW     = 1'b0,
    parameter int unsigned LONG_DELAY     = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] button_in,
    output logic [CHANNELS-1:0] button_out,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] long_press
);

    localparam logic [COUNTER_BITS-1:0] CNT_LAST = COUNTER_BITS'(DEBOUNCE_DELAY - 1);
    localparam logic [COUNTER_BITS-1:0] CNT_ONE  = COUNTER_BITS'(1);

    // Reject parameter sets the counters cannot represent.
    if (CHANNELS == 0 || DEBOUNCE_DELAY == 0 || LONG_DELAY == 0 ||
        64'(DEBOUNCE_DELAY) >= (64'd1 << COUNTER_BITS)) begin : g_bad_params
        $error("debounce_multi: illegal parameter combination");
    end

    logic [CHANNELS-1:0]     sync1;
    logic [CHANNELS-1:0]     sync2;
    logic [CHANNELS-1:0]     level;
    logic [COUNTER_BITS-1:0] cnt      [CHANNELS];
    logic [COUNTER_BITS-1:0] cnt_next [CHANNELS];
    logic [CHANNELS-1:0]     out_next;
    logic [CHANNELS-1:0]     press_next;
    logic [CHANNELS-1:0]     release_next;

    assign level = sync2 ^ {CHANNELS{ACTIVE_LOW}};

    // A change is accepted only after DEBOUNCE_DELAY consecutive mismatching samples.
    always_comb begin
        out_next     = button_out;
        press_next   = '0;
        release_next = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            cnt_next[i] = '0;
            if (level[i] != button_out[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    out_next[i]     = level[i];
                    press_next[i]   = level[i];
                    release_next[i] = ~level[i];
                end else begin
                    cnt_next[i] = cnt[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1         <= '0;
            sync2         <= '0;
            button_out    <= '0;
            press         <= '0;
            release_pulse <= '0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1         <= button_in;
            sync2         <= sync1;
            button_out    <= out_next;
            press         <= press_next;
            release_pulse <= release_next;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

`ifdef DEBOUNCE_LONGPRESS_EN
    localparam int unsigned          HOLD_BITS = $clog2(LONG_DELAY + 1);
    localparam logic [HOLD_BITS-1:0] HOLD_MAX  = HOLD_BITS'(LONG_DELAY);
    localparam logic [HOLD_BITS-1:0] HOLD_ONE  = HOLD_BITS'(1);

    logic [HOLD_BITS-1:0] hold      [CHANNELS];
    logic [HOLD_BITS-1:0] hold_next [CHANNELS];
    logic [CHANNELS-1:0]  long_next;

    // Hold counter saturates at LONG_DELAY, so the pulse fires once per press.
    always_comb begin
        long_next = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            hold_next[i] = '0;
            if (button_out[i]) begin
                if (hold[i] != HOLD_MAX) begin
                    hold_next[i] = hold[i] + HOLD_ONE;
                    long_next[i] = (hold[i] == HOLD_MAX - HOLD_ONE);
                end else begin
                    hold_next[i] = hold[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            long_press <= '0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                hold[i] <= '0;
            end
        end else begin
            long_press <= long_next;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                hold[i] <= hold_next[i];
            end
        end
    end
`else
    assign long_press = '0;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: per-cycle comparison against a sliding-window model of the
// debounce rule, plus directed scenarios with hand-computed timing expectations.
module tb_debounce_multi;

    localparam int unsigned CH = 4;
    localparam int unsigned D  = 8;
    localparam int unsigned LD = 20;
`ifdef DEBOUNCE_LONGPRESS_EN
    localparam int LONG_EXP = 1;
`else
    localparam int LONG_EXP = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] button_in;
    logic [CH-1:0] button_out;
    logic [CH-1:0] press;
    logic [CH-1:0] release_pulse;
    logic [CH-1:0] long_press;

    debounce_multi #(
        .CHANNELS(CH), .DEBOUNCE_DELAY(D), .COUNTER_BITS(20),
        .ACTIVE_LOW(1'b0), .LONG_DELAY(LD)
    ) dut (
        .clk(clk), .reset(reset), .button_in(button_in),
        .button_out(button_out), .press(press),
        .release_pulse(release_pulse), .long_press(long_press)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model state: 2-stage input delay, last D synchronised samples per channel.
    logic [CH-1:0] m_out = '0, m_press = '0, m_rel = '0, m_long = '0;
    bit  sp1 [CH];
    bit  sp2 [CH];
    bit  hist [CH][$];
    int  held [CH];

    // Event log taken from the DUT outputs.
    int last_press [CH];
    int last_rel   [CH];
    int last_long  [CH];
    int n_press    [CH];
    int n_rel      [CH];
    int n_long     [CH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model update, then compare every cycle.
    always @(posedge clk) begin : model
        logic          r;
        logic [CH-1:0] bi;
        bit            sv;
        bit            all_diff;
        r  = reset;
        bi = button_in;
        cyc++;
        m_press = '0;
        m_rel   = '0;
        m_long  = '0;
        if (r) begin
            m_out = '0;
            for (int c = 0; c < CH; c++) begin
                sp1[c] = 0; sp2[c] = 0; held[c] = 0;
                hist[c].delete();
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                sv = sp2[c];
                sp2[c] = sp1[c];
                sp1[c] = bi[c];
`ifdef DEBOUNCE_LONGPRESS_EN
                if (m_out[c]) begin
                    if (held[c] < int'(LD)) begin
                        held[c]++;
                        if (held[c] == int'(LD)) m_long[c] = 1'b1;
                    end
                end else begin
                    held[c] = 0;
                end
`endif
                hist[c].push_back(sv);
                if (hist[c].size() > int'(D)) void'(hist[c].pop_front());
                all_diff = (hist[c].size() == int'(D));
                for (int j = 0; j < hist[c].size(); j++)
                    if (hist[c][j] == m_out[c]) all_diff = 0;
                if (all_diff) begin
                    m_out[c] = ~m_out[c];
                    if (m_out[c]) m_press[c] = 1'b1;
                    else          m_rel[c]   = 1'b1;
                end
            end
        end
        #1;
        chk("button_out", 32'(button_out), 32'(m_out));
        chk("press", 32'(press), 32'(m_press));
        chk("release", 32'(release_pulse), 32'(m_rel));
        chk("long_press", 32'(long_press), 32'(m_long));
        for (int c = 0; c < CH; c++) begin
            if (press[c])         begin n_press[c]++; last_press[c] = cyc; end
            if (release_pulse[c]) begin n_rel[c]++;   last_rel[c]   = cyc; end
            if (long_press[c])    begin n_long[c]++;  last_long[c]  = cyc; end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int activity();
        int a = 0;
        for (int c = 0; c < CH; c++) a += n_press[c] + n_rel[c];
        return a;
    endfunction

    task automatic wait_press(input int c, input int n0, input int limit);
        int k = 0;
        while (n_press[c] == n0 && k < limit) begin @(negedge clk); k++; end
        if (n_press[c] == n0) begin
            errors++;
            $display("FAIL wait_press ch%0d: no pulse within %0d cycles", c, limit);
        end
    endtask

    task automatic wait_rel(input int c, input int n0, input int limit);
        int k = 0;
        while (n_rel[c] == n0 && k < limit) begin @(negedge clk); k++; end
        if (n_rel[c] == n0) begin
            errors++;
            $display("FAIL wait_release ch%0d: no pulse within %0d cycles", c, limit);
        end
    endtask

    initial begin : stim
        int k, a0, p0, r0, l0, p2, r2, rc;
        for (int c = 0; c < CH; c++) begin
            n_press[c] = 0; n_rel[c] = 0; n_long[c] = 0;
            last_press[c] = 0; last_rel[c] = 0; last_long[c] = 0;
            held[c] = 0;
        end
        reset     = 1'b1;
        button_in = 4'hF;

        // 1. reset with inputs high
        step(5);
        chk("t1 reset out", 32'(button_out), 32'h0);
        chk("t1 reset press", 32'(press | release_pulse | long_press), 32'h0);
        reset = 1'b0;
        step(1);
        chk("t1 first out", 32'(button_out), 32'h0);
        chk("t1 first pulses", 32'(press | release_pulse | long_press), 32'h0);
        button_in = 4'h0;
        step(12);

        // 2. bounce on ch0, then settle high
        a0 = activity();
        p0 = n_press[0];
        for (int i = 0; i < 10; i++) begin
            button_in[0] = (i % 2 == 0);
            step(3);
        end
        chk("t2 quiet bounce", 32'(activity() - a0), 32'h0);
        button_in[0] = 1'b1;
        k = cyc;
        wait_press(0, p0, 30);
        chk("t2 latency", 32'(last_press[0] - k), 32'd10);
        chk("t2 level", 32'(button_out[0]), 32'h1);
        step(1);
        chk("t2 one-cycle press", 32'(press[0]), 32'h0);
        chk("t2 single press", 32'(n_press[0] - p0), 32'h1);

        // 3. glitch of 7 cycles, then a valid 8-cycle pulse on ch2
        step(5);
        p2 = n_press[2];
        r2 = n_rel[2];
        button_in[2] = 1'b1;
        step(7);
        button_in[2] = 1'b0;
        step(15);
        chk("t3 glitch press", 32'(n_press[2] - p2), 32'h0);
        chk("t3 glitch release", 32'(n_rel[2] - r2), 32'h0);
        button_in[2] = 1'b1;
        step(8);
        button_in[2] = 1'b0;
        wait_rel(2, r2, 30);
        chk("t3 accepted press", 32'(n_press[2] - p2), 32'h1);
        chk("t3 press-release gap", 32'(last_rel[2] - last_press[2]), 32'd8);

        // 4. ch1 and ch3 step together
        step(3);
        p0 = n_press[0]; r0 = n_rel[0]; p2 = n_press[2];
        k = n_press[1];
        button_in[1] = 1'b1;
        button_in[3] = 1'b1;
        rc = cyc;
        wait_press(1, k, 30);
        chk("t4 simultaneous", 32'(last_press[3]), 32'(last_press[1]));
        chk("t4 latency", 32'(last_press[1] - rc), 32'd10);
        chk("t4 ch0/ch2 quiet", 32'((n_press[0] - p0) + (n_rel[0] - r0) + (n_press[2] - p2)), 32'h0);

        // 5. reset mid-count discards progress
        button_in = 4'h0;
        step(15);
        a0 = activity();
        p0 = n_press[0];
        button_in[0] = 1'b1;
        step(5);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        rc = cyc;
        chk("t5 reset out", 32'(button_out), 32'h0);
        chk("t5 reset pulses", 32'(press | release_pulse), 32'h0);
        chk("t5 no pulses", 32'(activity() - a0), 32'h0);
        wait_press(0, p0, 30);
        chk("t5 latency", 32'(last_press[0] - rc), 32'd10);
        chk("t5 single press", 32'(n_press[0] - p0), 32'h1);

        // 6. long press: hold 40 cycles, release, press again
        l0 = n_long[0];
        k  = last_press[0];
        step(40);
        chk("t6 long count", 32'(n_long[0] - l0), 32'(LONG_EXP));
        if (LONG_EXP != 0) chk("t6 long delay", 32'(last_long[0] - k), 32'd20);
        button_in[0] = 1'b0;
        step(15);
        p0 = n_press[0];
        button_in[0] = 1'b1;
        wait_press(0, p0, 30);
        k = last_press[0];
        step(25);
        chk("t6 re-armed", 32'(n_long[0] - l0), 32'(2 * LONG_EXP));
        if (LONG_EXP != 0) chk("t6 second delay", 32'(last_long[0] - k), 32'd20);
        if (LONG_EXP == 0) chk("t6 long idle", 32'(n_long[0] + n_long[1] + n_long[2] + n_long[3]), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
